// File: rtl/quad_demux_router_pkg.sv
// Shared types for the quad demux router: buffer occupancy encoding and port select values.
package quad_demux_router_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_cnt_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/quad_demux_obuf.sv
// Two-entry output buffer with valid/ready pop; head register drives the output directly.
module quad_demux_obuf
  import quad_demux_router_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output buf_cnt_e     o_cnt
);

  buf_cnt_e     r_cnt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_second;
  logic         w_pop;

  assign w_pop   = (r_cnt != EMPTY) && i_ready;
  assign o_data  = r_head;
  assign o_valid = (r_cnt != EMPTY);
  assign o_cnt   = r_cnt;

  // Head is left untouched when draining to EMPTY, so o_data keeps the last popped word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= EMPTY;
      r_head   <= '0;
      r_second <= '0;
    end else begin
      case (r_cnt)
        EMPTY: begin
          if (i_push) begin
            r_head <= i_data;
            r_cnt  <= ONE;
          end
        end
        ONE: begin
          if (i_push && w_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_second <= i_data;
            r_cnt    <= TWO;
          end else if (w_pop) begin
            r_cnt <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head <= r_second;
            r_cnt  <= ONE;
          end
        end
        default: r_cnt <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/quad_demux_router.sv
// Routes one word stream to port A or B by select bit, or discards and counts it when disabled.
module quad_demux_router
  import quad_demux_router_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_sel,
  input  logic             in_dis,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [W-1:0]     b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  buf_cnt_e         w_a_cnt;
  buf_cnt_e         w_b_cnt;
  logic             w_acc;
  logic             w_push_a;
  logic             w_push_b;
  logic [CNT_W-1:0] r_drop;

  // Readiness looks only at occupancy, never at the consumer's ready, so a full buffer
  // refuses a push even in a cycle where it is being popped.
  always_comb begin
    in_ready = 1'b1;
    if (!in_dis)
      in_ready = (in_sel == SEL_B) ? (w_b_cnt != TWO) : (w_a_cnt != TWO);
  end

  assign w_acc    = in_valid && in_ready;
  assign w_push_a = w_acc && !in_dis && (in_sel == SEL_A);
  assign w_push_b = w_acc && !in_dis && (in_sel == SEL_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop <= '0;
    else if (w_acc && in_dis && (r_drop != {CNT_W{1'b1}}))
      r_drop <= r_drop + 1'b1;
  end

  assign drop_cnt = r_drop;

  quad_demux_obuf #(.W(W)) u_obuf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_a),
    .i_data  (in_data),
    .i_ready (a_ready),
    .o_data  (a_data),
    .o_valid (a_valid),
    .o_cnt   (w_a_cnt)
  );

  quad_demux_obuf #(.W(W)) u_obuf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_b),
    .i_data  (in_data),
    .i_ready (b_ready),
    .o_data  (b_data),
    .o_valid (b_valid),
    .o_cnt   (w_b_cnt)
  );

endmodule

// File: tb/tb_quad_demux_router.sv
// Directed bench for quad_demux_router; a second instance with CNT_W=2 checks drop saturation.
module tb_quad_demux_router;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_sel, in_dis, in_valid, in_ready;
  logic [3:0] a_data, b_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] drop_cnt;
  logic       s_in_ready, s_a_valid, s_b_valid;
  logic [3:0] s_a_data, s_b_data;
  logic [1:0] s_drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  quad_demux_router #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_dis(in_dis),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid),
    .a_ready(a_ready), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .drop_cnt(drop_cnt)
  );

  quad_demux_router #(.W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_dis(in_dis),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_data(s_a_data), .a_valid(s_a_valid),
    .a_ready(a_ready), .b_data(s_b_data), .b_valid(s_b_valid), .b_ready(b_ready),
    .drop_cnt(s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; checks then run away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic s, input logic e);
    in_valid = v; in_data = d; in_sel = s; in_dis = e;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #12;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    step();

    // single route to A
    a_ready = 1'b1;
    drive(1'b1, 4'hA, 1'b0, 1'b0);
    chk("t1_in_ready", in_ready, 1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t1_a_valid", a_valid, 1);
    chk("t1_a_data", a_data, 4'hA);
    chk("t1_b_valid", b_valid, 0);
    step();
    chk("t1_a_valid_gone", a_valid, 0);
    chk("t1_drop", drop_cnt, 0);

    // fill A and backpressure
    a_ready = 1'b0;
    drive(1'b1, 4'h1, 1'b0, 1'b0); step();
    drive(1'b1, 4'h2, 1'b0, 1'b0); step();
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t2_full_ready", in_ready, 0);
    step();
    chk("t2_hold_data", a_data, 4'h1);
    a_ready = 1'b1; #1;
    chk("t2_ready_no_pop_dep", in_ready, 0);
    step();
    chk("t2_out2", a_data, 4'h2);
    chk("t2_ready_after_pop", in_ready, 1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t2_out3", a_data, 4'h3);
    chk("t2_out3_valid", a_valid, 1);
    step();
    chk("t2_drained", a_valid, 0);

    // discards, with the CNT_W=2 instance saturating
    a_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), i[0], 1'b1);
      chk($sformatf("t4_ready%0d", i), in_ready, 1);
      step();
      if (i == 3) chk("t4_drop4", drop_cnt, 4);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t4_drop6", drop_cnt, 6);
    chk("t4_sat", s_drop_cnt, 3);
    chk("t4_no_a", a_valid, 0);
    chk("t4_no_b", b_valid, 0);

    // simultaneous push and pop in ONE
    drive(1'b1, 4'h7, 1'b0, 1'b0); step();
    chk("t5_head7", a_data, 4'h7);
    a_ready = 1'b1;
    drive(1'b1, 4'h8, 1'b0, 1'b0); step();
    a_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t5_head8", a_data, 4'h8);
    chk("t5_valid", a_valid, 1);
    a_ready = 1'b1; step();
    a_ready = 1'b0;
    chk("t5_was_one", a_valid, 0);

    // independence: A full, B still accepts
    drive(1'b1, 4'h6, 1'b0, 1'b0); step();
    drive(1'b1, 4'h7, 1'b0, 1'b0); step();
    drive(1'b1, 4'h5, 1'b1, 1'b0);
    chk("t3_b_ready", in_ready, 1);
    step();
    chk("t3_b_valid", b_valid, 1);
    chk("t3_b_data", b_data, 4'h5);
    chk("t3_a_held", a_data, 4'h6);
    drive(1'b1, 4'h9, 1'b1, 1'b0); step();
    drive(1'b1, 4'hF, 1'b1, 1'b0);
    chk("t3_b_full", in_ready, 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);

    // async reset mid-stream with both buffers at TWO
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_a_valid", a_valid, 0);
    chk("t6_b_valid", b_valid, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_sat_drop", s_drop_cnt, 0);
    chk("t6_b_data", b_data, 0);
    #3;
    rst_n = 1'b1;
    step();
    drive(1'b1, 4'hC, 1'b1, 1'b0);
    chk("t6_ready", in_ready, 1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t6_b_route", b_valid, 1);
    chk("t6_b_word", b_data, 4'hC);
    chk("t6_a_empty", a_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/quad_demux_router.md
Name: quad_demux_router

Overview:
- Inverse of the quad 2-to-1 selector: takes one W-bit word stream and routes each word to output port A or port B, chosen by a per-word select bit S.
- Active-high disable E: a word presented with E=1 is consumed and discarded, and a drop counter increments.
- Each output has a 2-entry buffer with valid/ready handshake, so the block decouples a single producer from two independent consumers.

Parameters:
- W, 4, data width of in_data, a_data, b_data.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  W  word to route
- in_sel  input  1  S: 0 routes to A, 1 routes to B
- in_dis  input  1  E: 1 discards the word, 0 routes it normally
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- a_data  output  W  head word of the A buffer
- a_valid  output  1  A buffer non-empty
- a_ready  input  1  A consumer takes the head word
- b_data  output  W  head word of the B buffer
- b_valid  output  1  B buffer non-empty
- b_ready  input  1  B consumer takes the head word
- drop_cnt  output  CNT_W  number of discarded words, saturating

Behaviour:
- Reset (async assert, sync release): both buffers EMPTY; a_valid=b_valid=0; a_data=b_data=0; drop_cnt=0. in_ready is combinational and follows the rules below immediately.
- Input accept: a word is accepted when in_valid && in_ready at a clk edge. in_sel and in_dis are sampled with in_data.
- in_ready:
  - in_dis=1: in_ready=1.
  - in_dis=0, in_sel=0: in_ready = (A count < 2).
  - in_dis=0, in_sel=1: in_ready = (B count < 2).
  - in_ready has no combinational dependence on a_ready or b_ready. A full buffer does not accept a new word even when it is popped in the same cycle.
- Discard: an accepted word with in_dis=1 writes to neither buffer. drop_cnt increments by 1 and holds at 2^CNT_W-1.
- Buffer state machine, one per output, count 0/1/2:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop; the head is replaced by the pushed word.
  - TWO -> ONE on pop; the second entry moves to the head.
  - Push is not possible in TWO.
  - Pop = x_valid && x_ready.
- Latency: a word accepted at edge N appears on x_data with x_valid=1 after edge N (visible in cycle N+1). There is no combinational in->out path.
- Ordering: words routed to the same port leave in acceptance order. The two ports are independent; a stalled port never blocks words addressed to the other port.
- Head-of-line: if the current word targets a full port, in_ready=0 and the producer must hold in_valid, in_data, in_sel and in_dis stable until acceptance. The block does not reorder around it.
- Output stability: while x_valid && !x_ready, x_data and x_valid hold.
- x_data when x_valid=0: holds the last popped value; consumers must not rely on it.
- x_ready asserted while x_valid=0: no effect.
- Reset mid-operation: all buffered words are lost, counts go to 0, and drop_cnt clears.

Decomposition:
- Shared package: buffer count encoding (EMPTY=0, ONE=1, TWO=2) as a 2-bit typedef, and the SEL_A=0 / SEL_B=1 constants.
- One sub-module, quad_demux_obuf: a 2-entry W-bit buffer with push/pop, count state, and head/second registers. Instantiated twice, once for A and once for B.
- The top holds push steering, in_ready logic and drop_cnt.

Test Plan:
- Reset then single route: in_data=4'hA, in_sel=0, in_dis=0, in_valid pulse with a_ready=1 -> a_valid=1, a_data=4'hA in the next cycle only; b_valid stays 0; drop_cnt=0.
- Fill and backpressure: a_ready=0, three words 4'h1, 4'h2, 4'h3 to A -> first two accepted; in_ready=0 on the third. Then a_ready=1 -> outputs 4'h1, 4'h2, then 4'h3 in order.
- Independence: A full (a_ready=0), then send 4'h5 to B -> accepted the same cycle, and b_data=4'h5 appears next cycle.
- Discard: four words with in_dis=1 -> in_ready=1 throughout, no valid on A or B, drop_cnt=4. With CNT_W=2, six drops -> drop_cnt=3 (saturated).
- Simultaneous push/pop in ONE: A holds 4'h7; push 4'h8 while a_ready=1 -> 4'h7 pops; next cycle a_data=4'h8 and count stays ONE.
- Async reset mid-stream: assert rst_n=0 between edges with both buffers at TWO -> a_valid=b_valid=0 and drop_cnt=0 immediately. After release, the next word routes normally.
